// File: rtl/jk_bank_ctrl.sv
// jk_bank_ctrl: command-driven controller for a bank of WIDTH JK flip-flops.
// Accepts one command in IDLE. It drives per-bit J/K for one step, or for
// cmd_len+1 steps when counting. It then pulses done for one cycle.
module jk_bank_ctrl #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [3:0]       cmd_len,
  output logic [WIDTH-1:0] j_out,
  output logic [WIDTH-1:0] k_out,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done
);

  localparam int unsigned OP_W  = 3;
  localparam int unsigned LEN_W = 4;

  localparam logic [OP_W-1:0] OP_NOP    = 3'b000;
  localparam logic [OP_W-1:0] OP_CLEAR  = 3'b001;
  localparam logic [OP_W-1:0] OP_SET    = 3'b010;
  localparam logic [OP_W-1:0] OP_TOGGLE = 3'b011;
  localparam logic [OP_W-1:0] OP_LOAD   = 3'b100;
  localparam logic [OP_W-1:0] OP_UP     = 3'b101;
  localparam logic [OP_W-1:0] OP_DOWN   = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [OP_W-1:0]  op_q;
  logic [WIDTH-1:0] data_q;
  logic [LEN_W-1:0] cnt_q;
  logic [WIDTH-1:0] up_drv, dn_drv, q_next;
  logic             accept, is_count, last_step;

  assign accept    = cmd_valid && (state == IDLE);
  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign is_count  = (op_q == OP_UP) || (op_q == OP_DOWN);

  // Counter toggle masks: bit i toggles when all lower bits are 1 (up) or 0 (down).
  always_comb begin
    logic c_up, c_dn;
    c_up   = 1'b1;
    c_dn   = 1'b1;
    up_drv = '0;
    dn_drv = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      up_drv[i] = c_up;
      dn_drv[i] = c_dn;
      c_up      = c_up & q[i];
      c_dn      = c_dn & ~q[i];
    end
  end

  // Next-state and J/K drive; the bank only moves in EXEC.
  always_comb begin
    state_next = state;
    j_out      = '0;
    k_out      = '0;
    last_step  = 1'b1;
    case (state)
      IDLE: begin
        if (cmd_valid) state_next = EXEC;
      end
      EXEC: begin
        case (op_q)
          OP_CLEAR:  begin j_out = '0;      k_out = '1;      end
          OP_SET:    begin j_out = '1;      k_out = '0;      end
          OP_TOGGLE: begin j_out = data_q;  k_out = data_q;  end
          OP_LOAD:   begin j_out = data_q;  k_out = ~data_q; end
          OP_UP:     begin j_out = up_drv;  k_out = up_drv;  end
          OP_DOWN:   begin j_out = dn_drv;  k_out = dn_drv;  end
          default:   begin j_out = '0;      k_out = '0;      end
        endcase
        if (is_count) last_step = (cnt_q == '0);
        if (last_step) state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // JK flip-flop update rule applied per bit.
  always_comb begin
    q_next = q;
    for (int i = 0; i < int'(WIDTH); i++) begin
      case ({j_out[i], k_out[i]})
        2'b01:   q_next[i] = 1'b0;
        2'b10:   q_next[i] = 1'b1;
        2'b11:   q_next[i] = ~q[i];
        default: q_next[i] = q[i];
      endcase
    end
  end

  // State, bank, latched command and step counter; reset wins over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      q      <= '0;
      op_q   <= '0;
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      state <= state_next;
      q     <= q_next;
      if (accept) begin
        op_q   <= cmd_op;
        data_q <= cmd_data;
        cnt_q  <= cmd_len;
      end else if (state == EXEC && is_count && cnt_q != '0) begin
        cnt_q <= cnt_q - LEN_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_jk_bank_ctrl.sv
// Directed self-checking bench for jk_bank_ctrl (WIDTH = 4).
module tb_jk_bank_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [3:0] cmd_data;
  logic [3:0] cmd_len;
  logic [3:0] j_out, k_out, q;
  logic       busy, done;

  int vectors = 0;
  int errors  = 0;

  jk_bank_ctrl #(.WIDTH(4)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_len(cmd_len),
    .j_out(j_out), .k_out(k_out), .q(q),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle before driving/sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a command for one edge; returns in the first EXEC cycle.
  task automatic send(input logic [2:0] op, input logic [3:0] data, input logic [3:0] len);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    cmd_len   = len;
    step();
    cmd_valid = 1'b0;
  endtask

  // Single-step command: check result in DONE, then ready again in IDLE.
  task automatic run1(input string tag, input logic [2:0] op, input logic [3:0] data,
                      input logic [3:0] exp_q);
    send(op, data, 4'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    step();
    chk({tag, "_q"}, 32'(q), 32'(exp_q));
    chk({tag, "_done"}, 32'(done), 32'd1);
    step();
    chk({tag, "_ready"}, 32'(cmd_ready), 32'd1);
    chk({tag, "_done_low"}, 32'(done), 32'd0);
  endtask

  logic [3:0] up_seq [4];
  logic [3:0] dn_seq [3];
  logic [3:0] up15_seq [5];

  initial begin
    up_seq   = '{4'b1111, 4'b0000, 4'b0001, 4'b0010};
    dn_seq   = '{4'b0000, 4'b1111, 4'b1110};
    up15_seq = '{4'b0110, 4'b0111, 4'b1000, 4'b1001, 4'b1010};
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0; cmd_len = '0;
    #1;
    step();
    step();
    chk("rst_q", 32'(q), 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_jk", 32'({j_out, k_out}), 32'd0);
    reset = 1'b0;
    step();

    // LOAD 1010 with detailed latency checks
    send(3'b100, 4'b1010, 4'd0);
    chk("load_ready_low", 32'(cmd_ready), 32'd0);
    chk("load_j", 32'(j_out), 32'b1010);
    chk("load_k", 32'(k_out), 32'b0101);
    chk("load_q_before", 32'(q), 32'd0);
    step();
    chk("load_q", 32'(q), 32'b1010);
    chk("load_done", 32'(done), 32'd1);
    chk("load_jk_done", 32'({j_out, k_out}), 32'd0);
    step();
    chk("load_ready", 32'(cmd_ready), 32'd1);
    chk("load_done_once", 32'(done), 32'd0);

    run1("toggle", 3'b011, 4'b0110, 4'b1100);
    run1("clear",  3'b001, 4'b1010, 4'b0000);
    run1("set",    3'b010, 4'b0000, 4'b1111);

    // COUNT_UP len=3 from 1110, wraps through 0000
    run1("load_e", 3'b100, 4'b1110, 4'b1110);
    send(3'b101, 4'b0000, 4'd3);
    chk("up_j0", 32'(j_out), 32'b0001);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("up_busy%0d", i), 32'(busy), 32'd1);
      chk($sformatf("up_nodone%0d", i), 32'(done), 32'd0);
      step();
      chk($sformatf("up_q%0d", i), 32'(q), 32'(up_seq[i]));
    end
    chk("up_done", 32'(done), 32'd1);
    step();
    chk("up_ready", 32'(cmd_ready), 32'd1);

    // COUNT_DOWN len=2 from 0001 with cmd_valid held high (SET must not be taken)
    run1("load_1", 3'b100, 4'b0001, 4'b0001);
    send(3'b110, 4'b0000, 4'd2);
    cmd_valid = 1'b1;
    cmd_op    = 3'b010;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("dn_ready_low%0d", i), 32'(cmd_ready), 32'd0);
      step();
      chk($sformatf("dn_q%0d", i), 32'(q), 32'(dn_seq[i]));
    end
    chk("dn_done", 32'(done), 32'd1);
    step();
    chk("dn_idle_q", 32'(q), 32'b1110);
    chk("dn_idle_ready", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b0;
    step();

    // COUNT_DOWN len=0 from 1110 is a single step
    send(3'b110, 4'b0000, 4'd0);
    step();
    chk("dn0_q", 32'(q), 32'b1101);
    chk("dn0_done", 32'(done), 32'd1);
    step();

    // COUNT_UP len=15 from 0101, reset in the 6th EXEC cycle
    run1("load_5", 3'b100, 4'b0101, 4'b0101);
    send(3'b101, 4'b0000, 4'd15);
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("up15_q%0d", i), 32'(q), 32'(up15_seq[i]));
    end
    chk("up15_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_q", 32'(q), 32'd0);
    chk("abort_ready", 32'(cmd_ready), 32'd1);
    chk("abort_done", 32'(done), 32'd0);
    step();
    chk("abort_nodone", 32'(done), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);

    // Reset beats a command offered on the same edge
    cmd_valid = 1'b1; cmd_op = 3'b010; reset = 1'b1;
    step();
    cmd_valid = 1'b0; reset = 1'b0;
    chk("rst_prio_busy", 32'(busy), 32'd0);
    step();
    chk("rst_prio_q", 32'(q), 32'd0);

    // Reserved opcode 111 behaves as NOP
    run1("load_3", 3'b100, 4'b0011, 4'b0011);
    run1("rsvd", 3'b111, 4'b1111, 4'b0011);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
